// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered WIDTH-bit bitwise logic unit with
// valid/ready streaming, reduction flags and a gate self-test sequencer.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid/in_ready         operand handshake (in_a, in_b, in_op)
//   out_valid/out_ready       result handshake (out_y, out_any, out_all)
//   bist_start                pulse, starts self-test from IDLE
//   fault_inject              inverts y[0] of the shared op mux
//   bist_busy/done/fail       self-test status, bist_fail_op = first bad op
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_any,
  output logic             out_all,
  input  logic             bist_start,
  input  logic             fault_inject,
  output logic             bist_busy,
  output logic             bist_done,
  output logic             bist_fail,
  output logic [2:0]       bist_fail_op
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    RUN,
    DONE
  } state_t;

  // Expected self-test bit, indexed by {op, combo}; one nibble per op.
  localparam logic [31:0] EXP = {
    4'b1100, // PASS A
    4'b0011, // NOT A
    4'b0001, // NOR
    4'b0111, // NAND
    4'b1001, // XNOR
    4'b0110, // XOR
    4'b1110, // OR
    4'b1000  // AND
  };

  state_t           state;
  logic [4:0]       cnt;
  logic [2:0]       mux_op;
  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] mux_b;
  logic [WIDTH-1:0] y_raw;
  logic [WIDTH-1:0] y;
  logic             accept;
  logic             chk_bad;

  // The self-test borrows the stream datapath while in RUN.
  always_comb begin
    mux_op = in_op;
    mux_a  = in_a;
    mux_b  = in_b;
    if (state == RUN) begin
      mux_op = cnt[4:2];
      mux_a  = {WIDTH{cnt[1]}};
      mux_b  = {WIDTH{cnt[0]}};
    end
  end

  always_comb begin
    y_raw = '0;
    case (mux_op)
      3'd0: y_raw = mux_a & mux_b;
      3'd1: y_raw = mux_a | mux_b;
      3'd2: y_raw = mux_a ^ mux_b;
      3'd3: y_raw = ~(mux_a ^ mux_b);
      3'd4: y_raw = ~(mux_a & mux_b);
      3'd5: y_raw = ~(mux_a | mux_b);
      3'd6: y_raw = ~mux_a;
      default: y_raw = mux_a;
    endcase
  end

  always_comb begin
    y    = y_raw;
    y[0] = y_raw[0] ^ fault_inject;
  end

  assign in_ready = (state == IDLE) && !bist_busy &&
                    (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign chk_bad  = (y != {WIDTH{EXP[cnt]}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      out_valid    <= 1'b0;
      out_y        <= '0;
      out_any      <= 1'b0;
      out_all      <= 1'b0;
      bist_busy    <= 1'b0;
      bist_done    <= 1'b0;
      bist_fail    <= 1'b0;
      bist_fail_op <= '0;
    end else begin
      bist_done <= 1'b0;

      if (accept) begin
        out_valid <= 1'b1;
        out_y     <= y;
        out_any   <= |y;
        out_all   <= &y;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bist_start) begin
            state        <= DRAIN;
            cnt          <= '0;
            bist_busy    <= 1'b1;
            bist_fail    <= 1'b0;
            bist_fail_op <= '0;
          end
        end
        DRAIN: begin
          // Leave once any pending result is gone or leaves this edge.
          if (!out_valid || out_ready) state <= RUN;
        end
        RUN: begin
          if (chk_bad) begin
            bist_fail <= 1'b1;
            if (!bist_fail) bist_fail_op <= cnt[4:2];
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state     <= DONE;
            bist_done <= 1'b1;
            bist_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
